// File: rtl/adder_arbiter.sv
// Two-requester front end for a shared combinational adder: round-robin grant,
// one-cycle calculate, then hold the captured result until the consumer takes it.
module adder_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_q,
  input  logic             add_ovf,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_q,
  output logic             rsp_ovf,
  input  logic             rsp_ready
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             id_q, id_d, prio_q, prio_d, ovf_q, ovf_d, rid_q, rid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      ovf_q   <= ovf_d;
      rid_q   <= rid_d;
    end
  end

  // prio_q names the requester that wins when both are valid; a lone
  // requester is granted regardless and then loses priority to the other.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    id_d       = id_q;
    prio_d     = prio_q;
    ovf_d      = ovf_q;
    rid_d      = rid_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid && (!req1_valid || !prio_q)) begin
          req0_ready = 1'b1;
          a_d        = req0_a;
          b_d        = req0_b;
          id_d       = 1'b0;
          prio_d     = 1'b1;
          state_d    = CALC;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
          a_d        = req1_a;
          b_d        = req1_b;
          id_d       = 1'b1;
          prio_d     = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        res_d   = add_q;
        ovf_d   = add_ovf;
        rid_d   = id_q;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign add_a   = a_q;
  assign add_b   = b_q;
  assign rsp_q   = res_q;
  assign rsp_ovf = ovf_q;
  assign rsp_id  = rid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural 5-bit adder attached.
module tb_adder_arbiter;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [WIDTH-1:0] add_a, add_b, add_q, rsp_q;
  logic             add_ovf, rsp_valid, rsp_id, rsp_ovf, rsp_ready;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  assign {add_ovf, add_q} = {1'b0, add_a} + {1'b0, add_b};

  adder_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .add_a(add_a), .add_b(add_b), .add_q(add_q), .add_ovf(add_ovf),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_ovf(rsp_ovf),
    .rsp_ready(rsp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int grants;
    int order [4];
    logic [2:0] hold_q;

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    tick(); tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_rsp_q", rsp_q, 0);
    chk("rst_ready0", req0_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req_ready0", req0_ready, 0);
    chk("idle_no_req_ready1", req1_ready, 0);

    // Single request 3+4, operands disturbed right after the handshake
    req0_valid = 1; req0_a = 3; req0_b = 4;
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    tick();
    req0_valid = 0; req0_a = 9; req0_b = 9;
    #1;
    chk("calc_ready0", req0_ready, 0);
    chk("calc_rsp_valid", rsp_valid, 0);
    chk("calc_add_a", add_a, 3);
    chk("calc_add_b", add_b, 4);
    tick();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_q", rsp_q, 7);
    chk("single_rsp_ovf", rsp_ovf, 0);
    chk("single_rsp_id", rsp_id, 0);
    rsp_ready = 1;
    tick();
    chk("single_done_valid", rsp_valid, 0);
    chk("single_hold_q", rsp_q, 7);

    // Overflow on requester 1: 20+15 = 35 -> 3 with carry
    req1_valid = 1; req1_a = 20; req1_b = 15;
    #1;
    chk("ovf_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    chk("ovf_rsp_valid", rsp_valid, 1);
    chk("ovf_rsp_q", rsp_q, 3);
    chk("ovf_rsp_ovf", rsp_ovf, 1);
    chk("ovf_rsp_id", rsp_id, 1);
    tick();

    // Backpressure: req0 1+2, consumer stalls, req1 waits meanwhile
    rsp_ready = 0;
    req0_valid = 1; req0_a = 1; req0_b = 2;
    #1;
    chk("bp_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 5; req1_b = 6;
    #1;
    chk("bp_calc_ready1", req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_q", rsp_q, 3);
      chk("bp_ovf", rsp_ovf, 0);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready1", req1_ready, 0);
      tick();
    end
    rsp_ready = 1;
    #1;
    chk("bp_release_ready1", req1_ready, 0);
    tick();
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_next_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    chk("bp_next_q", rsp_q, 11);
    chk("bp_next_id", rsp_id, 1);
    tick();

    // Reset while holding a response
    rsp_ready = 0;
    req0_valid = 1; req0_a = 10; req0_b = 12;
    tick();
    req0_valid = 0;
    tick();
    chk("mid_rsp_q", rsp_q, 22);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_q", rsp_q, 0);
    chk("arst_rsp_id", rsp_id, 0);
    chk("arst_add_a", add_a, 0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1;
    hold_q = '0;
    for (int i = 0; i < 4; i++) begin
      hold_q = hold_q | {2'b0, rsp_valid};
      tick();
    end
    chk("arst_no_resp", hold_q, 0);

    // Contention from reset: grants must alternate starting with requester 0
    rst_n = 1'b0;
    tick();
    req0_valid = 1; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_a = 2; req1_b = 2;
    rst_n = 1'b1;
    #1;
    grants = 0;
    for (int c = 0; c < 30 && grants < 4; c++) begin
      if (req0_ready && req1_ready) chk("cont_both_ready", 1, 0);
      if (req0_ready) begin order[grants] = 0; grants++; end
      else if (req1_ready) begin order[grants] = 1; grants++; end
      tick();
    end
    chk("cont_grants", grants, 4);
    for (int g = 0; g < 4; g++) chk($sformatf("cont_order%0d", g), order[g], g % 2);
    req0_valid = 0; req1_valid = 0;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
